// File: rtl/mem_port_arbiter_pkg.sv
// Shared memory-port types: access sizes plus arbiter state and owner encodings.
`timescale 1ns/1ps
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        MEM_ACCESS_SIZE_BYTE = 2'd0,
        MEM_ACCESS_SIZE_HALF = 2'd1,
        MEM_ACCESS_SIZE_WORD = 2'd2
    } mem_access_size_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        ARB_OWNER_IMEM = 1'b0,
        ARB_OWNER_DMEM = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory bus port between fetch and load/store.
// Data wins by default; a starvation counter forces periodic fetch grants.
`timescale 1ns/1ps
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              imem_valid_i,
    input  logic [ADDR_W-1:0] imem_addr_i,
    input  logic              imem_flush_i,
    output logic              imem_ready_o,
    output logic              imem_rvalid_o,
    output logic [DATA_W-1:0] imem_rdata_o,
    input  logic              dmem_valid_i,
    input  logic [ADDR_W-1:0] dmem_addr_i,
    input  logic              dmem_we_i,
    input  logic [1:0]        dmem_size_i,
    input  logic [DATA_W-1:0] dmem_wdata_i,
    output logic              dmem_ready_o,
    output logic              dmem_rvalid_o,
    output logic [DATA_W-1:0] dmem_rdata_o,
    output logic              bus_valid_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic              bus_we_o,
    output logic [1:0]        bus_size_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_ready_i,
    input  logic              bus_rvalid_i,
    input  logic [DATA_W-1:0] bus_rdata_i
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    arb_state_t       state_q, state_d;
    arb_owner_t       owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic             we_q, we_d;
    mem_access_size_t size_q, size_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             drop_q, drop_d;

    logic grant_any;
    logic pick_imem;
    logic issue;
    logic resp;
    logic imem_owns;

    always_comb begin
        grant_any = 1'b0;
        pick_imem = 1'b0;
        if (!reset_i && state_q == ARB_IDLE) begin
            grant_any = imem_valid_i | dmem_valid_i;
            pick_imem = imem_valid_i &
                        (~dmem_valid_i | (starve_q == LIMIT));
        end
    end

    assign imem_owns = (owner_q == ARB_OWNER_IMEM);

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        we_d     = we_q;
        size_d   = size_q;
        wdata_d  = wdata_q;
        starve_d = starve_q;
        drop_d   = drop_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (grant_any) begin
                    state_d = ARB_ISSUE;
                    if (pick_imem) begin
                        owner_d  = ARB_OWNER_IMEM;
                        addr_d   = imem_addr_i;
                        we_d     = 1'b0;
                        size_d   = MEM_ACCESS_SIZE_WORD;
                        wdata_d  = '0;
                        starve_d = '0;
                        drop_d   = imem_flush_i;
                    end else begin
                        owner_d = ARB_OWNER_DMEM;
                        addr_d  = dmem_addr_i;
                        we_d    = dmem_we_i;
                        size_d  = mem_access_size_t'(dmem_size_i);
                        wdata_d = dmem_wdata_i;
                        drop_d  = 1'b0;
                        // Count only grants that actually made a fetch wait
                        if (!imem_valid_i) begin
                            starve_d = '0;
                        end else if (starve_q != LIMIT) begin
                            starve_d = starve_q + CNT_W'(1);
                        end
                    end
                end
            end
            ARB_ISSUE: begin
                if (imem_owns && imem_flush_i) begin
                    drop_d = 1'b1;
                end
                if (bus_ready_i) begin
                    state_d = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (imem_owns && imem_flush_i) begin
                    drop_d = 1'b1;
                end
                if (bus_rvalid_i) begin
                    state_d = ARB_IDLE;
                    drop_d  = 1'b0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= ARB_IDLE;
            owner_q  <= ARB_OWNER_IMEM;
            addr_q   <= '0;
            we_q     <= 1'b0;
            size_q   <= MEM_ACCESS_SIZE_BYTE;
            wdata_q  <= '0;
            starve_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            size_q   <= size_d;
            wdata_q  <= wdata_d;
            starve_q <= starve_d;
            drop_q   <= drop_d;
        end
    end

    assign issue = !reset_i && (state_q == ARB_ISSUE);
    assign resp  = !reset_i && (state_q == ARB_WAIT) && bus_rvalid_i;

    assign imem_ready_o = grant_any & pick_imem;
    assign dmem_ready_o = grant_any & ~pick_imem;

    // A flush arriving with the response also discards it
    assign imem_rvalid_o = resp & imem_owns & ~drop_q & ~imem_flush_i;
    assign dmem_rvalid_o = resp & ~imem_owns;
    assign imem_rdata_o  = imem_rvalid_o ? bus_rdata_i : '0;
    assign dmem_rdata_o  = dmem_rvalid_o ? bus_rdata_i : '0;

    assign bus_valid_o = issue;
    assign bus_addr_o  = issue ? addr_q : '0;
    assign bus_we_o    = issue & we_q;
    assign bus_size_o  = issue ? size_q : MEM_ACCESS_SIZE_BYTE;
    assign bus_wdata_o = issue ? wdata_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, corner sequences,
// and a random phase against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        imem_valid_i;
    logic [31:0] imem_addr_i;
    logic        imem_flush_i;
    logic        imem_ready_o;
    logic        imem_rvalid_o;
    logic [31:0] imem_rdata_o;
    logic        dmem_valid_i;
    logic [31:0] dmem_addr_i;
    logic        dmem_we_i;
    logic [1:0]  dmem_size_i;
    logic [31:0] dmem_wdata_i;
    logic        dmem_ready_o;
    logic        dmem_rvalid_o;
    logic [31:0] dmem_rdata_o;
    logic        bus_valid_o;
    logic [31:0] bus_addr_o;
    logic        bus_we_o;
    logic [1:0]  bus_size_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ready_i;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .imem_valid_i(imem_valid_i), .imem_addr_i(imem_addr_i),
        .imem_flush_i(imem_flush_i), .imem_ready_o(imem_ready_o),
        .imem_rvalid_o(imem_rvalid_o), .imem_rdata_o(imem_rdata_o),
        .dmem_valid_i(dmem_valid_i), .dmem_addr_i(dmem_addr_i),
        .dmem_we_i(dmem_we_i), .dmem_size_i(dmem_size_i),
        .dmem_wdata_i(dmem_wdata_i), .dmem_ready_o(dmem_ready_o),
        .dmem_rvalid_o(dmem_rvalid_o), .dmem_rdata_o(dmem_rdata_o),
        .bus_valid_o(bus_valid_o), .bus_addr_o(bus_addr_o),
        .bus_we_o(bus_we_o), .bus_size_o(bus_size_o),
        .bus_wdata_o(bus_wdata_o), .bus_ready_i(bus_ready_i),
        .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
    );

    typedef struct {
        logic        iv;
        logic [31:0] ia;
        logic        dv;
        logic [31:0] da;
        logic        dwe;
        logic [1:0]  dsz;
        logic [31:0] dwd;
        logic        br;
        logic        brv;
        logic [31:0] brd;
        logic        e_ir;
        logic        e_dr;
        logic        e_bv;
        logic [31:0] e_ba;
        logic        e_bwe;
        logic [1:0]  e_bsz;
        logic [31:0] e_bwd;
        logic        e_irv;
        logic [31:0] e_ird;
        logic        e_drv;
        logic [31:0] e_drd;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(string tag,
                           logic e_ir, logic e_dr, logic e_bv,
                           logic [31:0] e_ba, logic e_bwe,
                           logic [1:0] e_bsz, logic [31:0] e_bwd,
                           logic e_irv, logic [31:0] e_ird,
                           logic e_drv, logic [31:0] e_drd);
        chk({tag, ".imem_ready"}, 64'(imem_ready_o), 64'(e_ir));
        chk({tag, ".dmem_ready"}, 64'(dmem_ready_o), 64'(e_dr));
        chk({tag, ".bus_valid"}, 64'(bus_valid_o), 64'(e_bv));
        chk({tag, ".imem_rvalid"}, 64'(imem_rvalid_o), 64'(e_irv));
        chk({tag, ".imem_rdata"}, 64'(imem_rdata_o), 64'(e_ird));
        chk({tag, ".dmem_rvalid"}, 64'(dmem_rvalid_o), 64'(e_drv));
        chk({tag, ".dmem_rdata"}, 64'(dmem_rdata_o), 64'(e_drd));
        if (e_bv) begin
            chk({tag, ".bus_addr"}, 64'(bus_addr_o), 64'(e_ba));
            chk({tag, ".bus_we"}, 64'(bus_we_o), 64'(e_bwe));
            chk({tag, ".bus_size"}, 64'(bus_size_o), 64'(e_bsz));
            if (e_bwe) begin
                chk({tag, ".bus_wdata"}, 64'(bus_wdata_o), 64'(e_bwd));
            end
        end
    endtask

    task automatic chk_quiet(string tag);
        chk_all(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic clr_inputs();
        imem_valid_i = 0; imem_addr_i = 0; imem_flush_i = 0;
        dmem_valid_i = 0; dmem_addr_i = 0; dmem_we_i = 0;
        dmem_size_i = 0; dmem_wdata_i = 0;
        bus_ready_i = 0; bus_rvalid_i = 0; bus_rdata_i = 0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    task automatic do_reset();
        clr_inputs();
        reset_i = 1;
        nxt();
        nxt();
        reset_i = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Transaction-level reference model state
    bit          m_busy, m_acc, m_drop, m_own_i;
    logic [31:0] m_addr, m_wd;
    logic        m_we;
    logic [1:0]  m_sz;
    int          m_starve;

    initial begin
        string order;
        bit    riv, rdv;
        logic [31:0] ria, rda, rdwd;
        logic  rdwe;
        logic [1:0] rdsz;

        // table: fetch, byte store, fetch, half load with ready+rvalid together
        vecs[0]  = '{1, 32'h100, 0, 0, 0, 0, 0, 1, 1, 32'hAAAA,
                     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0,
                     0, 0, 1, 32'h100, 0, 2, 0, 0, 0, 0, 0};
        vecs[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF,
                     0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0};
        vecs[3]  = '{1, 32'h104, 1, 32'h2000, 1, 0, 32'hAB, 0, 0, 0,
                     0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[4]  = '{1, 32'h104, 0, 0, 0, 0, 0, 1, 0, 0,
                     0, 0, 1, 32'h2000, 1, 0, 32'hAB, 0, 0, 0, 0};
        vecs[5]  = '{1, 32'h104, 0, 0, 0, 0, 0, 0, 1, 32'h55,
                     0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h55};
        vecs[6]  = '{1, 32'h104, 0, 0, 0, 0, 0, 0, 0, 0,
                     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0,
                     0, 0, 1, 32'h104, 0, 2, 0, 0, 0, 0, 0};
        vecs[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h12345678,
                     0, 0, 0, 0, 0, 0, 0, 1, 32'h12345678, 0, 0};
        vecs[9]  = '{0, 0, 1, 32'h3000, 0, 1, 0, 0, 0, 0,
                     0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[10] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h99,
                     0, 0, 1, 32'h3000, 0, 1, 0, 0, 0, 0, 0};
        vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77,
                     0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77};
        vecs[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        clr_inputs();
        reset_i = 1;
        imem_valid_i = 1;
        nxt();
        half();
        chk_quiet("reset");
        nxt();
        imem_valid_i = 0;
        reset_i = 0;

        for (int i = 0; i < 14; i++) begin
            imem_valid_i = vecs[i].iv;  imem_addr_i  = vecs[i].ia;
            dmem_valid_i = vecs[i].dv;  dmem_addr_i  = vecs[i].da;
            dmem_we_i    = vecs[i].dwe; dmem_size_i  = vecs[i].dsz;
            dmem_wdata_i = vecs[i].dwd; bus_ready_i  = vecs[i].br;
            bus_rvalid_i = vecs[i].brv; bus_rdata_i  = vecs[i].brd;
            half();
            chk_all($sformatf("v%0d", i), vecs[i].e_ir, vecs[i].e_dr,
                    vecs[i].e_bv, vecs[i].e_ba, vecs[i].e_bwe,
                    vecs[i].e_bsz, vecs[i].e_bwd, vecs[i].e_irv,
                    vecs[i].e_ird, vecs[i].e_drv, vecs[i].e_drd);
            nxt();
        end

        // bus stall in ISSUE: fields stable, no new grants
        clr_inputs();
        dmem_valid_i = 1; dmem_addr_i = 32'h4000; dmem_we_i = 1;
        dmem_size_i = 2; dmem_wdata_i = 32'hCAFE;
        half(); chk_all("stall.grant", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nxt();
        clr_inputs();
        imem_valid_i = 1; imem_addr_i = 32'h200;
        for (int k = 0; k < 5; k++) begin
            half();
            chk_all($sformatf("stall%0d", k), 0, 0, 1, 32'h4000, 1, 2,
                    32'hCAFE, 0, 0, 0, 0);
            nxt();
        end
        bus_ready_i = 1;
        half(); chk_all("stall.acc", 0, 0, 1, 32'h4000, 1, 2, 32'hCAFE,
                        0, 0, 0, 0);
        nxt();
        bus_ready_i = 0; bus_rvalid_i = 1; bus_rdata_i = 32'h1111;
        half(); chk_all("stall.ack", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1111);
        nxt();
        bus_rvalid_i = 0;
        half(); chk_all("stall.ig", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nxt();

        // flush while fetch waits for its response
        imem_valid_i = 0; bus_ready_i = 1;
        half(); chk_all("fl.iss", 0, 0, 1, 32'h200, 0, 2, 0, 0, 0, 0, 0);
        nxt();
        bus_ready_i = 0; imem_flush_i = 1;
        half(); chk_quiet("fl.wait");
        nxt();
        imem_flush_i = 0; bus_rvalid_i = 1; bus_rdata_i = 32'hBAD0;
        half(); chk_quiet("fl.drop");
        nxt();
        bus_rvalid_i = 0;
        dmem_valid_i = 1; dmem_addr_i = 32'h5000; dmem_size_i = 2;
        half(); chk_all("fl.next", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nxt();
        dmem_valid_i = 0; bus_ready_i = 1;
        half(); chk_all("fl.iss2", 0, 0, 1, 32'h5000, 0, 2, 0, 0, 0, 0, 0);
        nxt();
        bus_ready_i = 0; bus_rvalid_i = 1; bus_rdata_i = 32'h5555;
        half(); chk_all("fl.rsp2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h5555);
        nxt();

        // reset while a fetch is in WAIT
        clr_inputs();
        imem_valid_i = 1; imem_addr_i = 32'h300;
        half(); chk_all("rs.grant", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nxt();
        imem_valid_i = 0; bus_ready_i = 1;
        half(); chk_all("rs.iss", 0, 0, 1, 32'h300, 0, 2, 0, 0, 0, 0, 0);
        nxt();
        bus_ready_i = 0; reset_i = 1; imem_valid_i = 1;
        bus_rvalid_i = 1; bus_rdata_i = 32'h6666;
        half(); chk_quiet("rs.during");
        nxt();
        reset_i = 0; imem_valid_i = 0;
        half(); chk_quiet("rs.after");
        nxt();
        bus_rvalid_i = 0; imem_valid_i = 1; imem_addr_i = 32'h400;
        half(); chk_all("rs.fresh", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nxt();
        imem_valid_i = 0; bus_ready_i = 1;
        half(); chk_all("rs.iss2", 0, 0, 1, 32'h400, 0, 2, 0, 0, 0, 0, 0);
        nxt();
        bus_ready_i = 0; bus_rvalid_i = 1; bus_rdata_i = 32'h4444;
        half(); chk_all("rs.rsp", 0, 0, 0, 0, 0, 0, 0, 1, 32'h4444, 0, 0);
        nxt();

        // both requesters saturate the port
        clr_inputs();
        imem_valid_i = 1; imem_addr_i = 32'h500;
        dmem_valid_i = 1; dmem_addr_i = 32'h6000; dmem_size_i = 2;
        bus_ready_i = 1; bus_rvalid_i = 1;
        order = "";
        for (int c = 0; c < 60 && order.len() < 10; c++) begin
            half();
            if (imem_ready_o) order = {order, "I"};
            if (dmem_ready_o) order = {order, "D"};
            nxt();
        end
        n_tests++;
        if (order != "DDDDIDDDDI") begin
            n_fail++;
            $display("FAIL starve_order: got %s expected DDDDIDDDDI", order);
        end

        // random traffic against the reference model
        do_reset();
        m_busy = 0; m_acc = 0; m_drop = 0; m_starve = 0;
        riv = 0; rdv = 0;
        ria = 0; rda = 0; rdwd = 0; rdwe = 0; rdsz = 0;
        for (int c = 0; c < 1500; c++) begin
            logic e_ir, e_dr, e_bv, e_irv, e_drv;
            logic [31:0] e_ird, e_drd;
            bit pick_i;
            if (!riv && $urandom_range(0, 2) == 0) begin
                riv = 1; ria = $urandom & 32'hFFFF_FFFC;
            end
            if (!rdv && $urandom_range(0, 2) == 0) begin
                rdv = 1; rda = $urandom; rdwe = 1'($urandom);
                rdsz = 2'($urandom_range(0, 2)); rdwd = $urandom;
            end
            imem_valid_i = riv; imem_addr_i = ria;
            dmem_valid_i = rdv; dmem_addr_i = rda; dmem_we_i = rdwe;
            dmem_size_i = rdsz; dmem_wdata_i = rdwd;
            imem_flush_i = ($urandom_range(0, 9) == 0);
            bus_ready_i = 1'($urandom);
            bus_rvalid_i = 1'($urandom);
            bus_rdata_i = $urandom;
            half();
            e_ir = 0; e_dr = 0; e_bv = 0; e_irv = 0; e_drv = 0;
            e_ird = 0; e_drd = 0;
            if (m_busy && !m_acc) e_bv = 1;
            if (m_busy && m_acc && bus_rvalid_i) begin
                if (m_own_i) e_irv = !(m_drop || imem_flush_i);
                else e_drv = 1;
            end
            if (e_irv) e_ird = bus_rdata_i;
            if (e_drv) e_drd = bus_rdata_i;
            if (!m_busy && (riv || rdv)) begin
                pick_i = riv && (!rdv || m_starve == LIMIT);
                e_ir = pick_i; e_dr = !pick_i;
            end
            chk_all($sformatf("rnd%0d", c), e_ir, e_dr, e_bv, m_addr,
                    m_we, m_sz, m_wd, e_irv, e_ird, e_drv, e_drd);
            if (!m_busy) begin
                if (e_ir) begin
                    m_busy = 1; m_acc = 0; m_own_i = 1; m_addr = ria;
                    m_we = 0; m_sz = 2; m_wd = 0; m_starve = 0;
                    m_drop = imem_flush_i; riv = 0;
                end else if (e_dr) begin
                    m_busy = 1; m_acc = 0; m_own_i = 0; m_addr = rda;
                    m_we = rdwe; m_sz = rdsz; m_wd = rdwd; m_drop = 0;
                    m_starve = riv ? (m_starve < LIMIT ? m_starve + 1
                                                       : LIMIT) : 0;
                    rdv = 0;
                end
            end else begin
                if (m_own_i && imem_flush_i) m_drop = 1;
                if (m_acc && bus_rvalid_i) m_busy = 0;
                else if (!m_acc && bus_ready_i) m_acc = 1;
            end
            nxt();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
